ppi_bus_master: RTL

- Synchronous CPU-side bus sequencer that sits directly upstream of the 8255-style PPI chip.
- Converts single-beat valid/ready register commands into correctly timed CS/RD/WR/A/data bus cycles, with programmable setup, strobe, hold and recovery phases.
- Captures read data and returns it as a one-cycle response.
- Also generates timed PPI reset pulses and keeps a shadow copy of the last control word written.

---
 rtl/ppi_bus_master_pkg.sv | 39 +++
 rtl/ppi_bus_master_if.sv | 24 ++
 rtl/ppi_bus_master.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ppi_bus_master_pkg.sv
// Shared types and constants for the 8255 PPI bus sequencer.
// Holds the state encoding, register addresses and control-word bit positions.
package ppi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_CHIPRST = 3'd5
  } ppi_state_e;

  localparam logic [1:0] ADDR_A    = 2'd0;
  localparam logic [1:0] ADDR_B    = 2'd1;
  localparam logic [1:0] ADDR_C    = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // Mode 0 with every port configured as input: what the chip holds after its own reset.
  localparam logic [7:0] CTRL_RESET_VAL = 8'h9B;

  localparam int MODE_SET = 7;
  localparam int A_IN     = 4;
  localparam int CU_IN    = 3;
  localparam int B_IN     = 1;
  localparam int CL_IN    = 0;

  function automatic int max_cyc(input int a, input int b, input int c, input int d,
                                 input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/ppi_bus_master_if.sv
// Command/response handshake between the CPU side and the PPI bus sequencer.
// The CPU is the master; the sequencer is the slave.
interface ppi_bus_master_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_write;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata
  );

endinterface

// File: rtl/ppi_bus_master.sv
// Sequences single-beat register commands into timed CS/RD/WR bus cycles on an 8255 PPI,
// and generates timed chip-reset pulses while tracking the last mode-set control word.
//
//   state   | meaning
//   IDLE    | waiting for a command or reset request; cmd_ready lives here
//   SETUP   | CS low, address and write data settling ahead of the strobe
//   STROBE  | RD_n or WR_n low; read data captured on the last edge
//   HOLD    | strobe released, CS/address/data still held
//   RECOVER | CS high between bus cycles; response pulse on the first cycle
//   CHIPRST | ppi_reset high for RESET_CYC cycles
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 3,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 2,
  parameter int RESET_CYC    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  ppi_bus_master_if.slave         bus,
  input  logic                    init_req,
  output logic                    init_done,
  output logic [7:0]              ctrl_shadow,
  output logic                    ppi_cs_n,
  output logic                    ppi_rd_n,
  output logic                    ppi_wr_n,
  output logic [1:0]              ppi_a,
  output logic                    ppi_reset,
  output logic [7:0]              ppi_d_out,
  output logic                    ppi_d_oe,
  input  logic [7:0]              ppi_d_in
);

  localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] S_SETUP   = 3'(ST_SETUP);
  localparam logic [2:0] S_STROBE  = 3'(ST_STROBE);
  localparam logic [2:0] S_HOLD    = 3'(ST_HOLD);
  localparam logic [2:0] S_RECOVER = 3'(ST_RECOVER);
  localparam logic [2:0] S_CHIPRST = 3'(ST_CHIPRST);

  localparam int MAX_CYC = max_cyc(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVERY_CYC, RESET_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LD    = CNT_W'(RECOVERY_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RESET_CYC - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;
  logic             lat_write;
  logic             rsp_valid_q;
  logic             rsp_write_q;
  logic [7:0]       rdata_q;

  assign cnt_done      = (cnt == '0);
  assign bus.cmd_ready = (state == S_IDLE) && !init_req && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rdata_q;

  // Bus pins are registered and updated on the same edge as the state change,
  // so each phase's pin levels appear exactly for that phase's cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lat_write   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rdata_q     <= 8'h00;
      init_done   <= 1'b0;
      ctrl_shadow <= CTRL_RESET_VAL;
      ppi_cs_n    <= 1'b1;
      ppi_rd_n    <= 1'b1;
      ppi_wr_n    <= 1'b1;
      ppi_a       <= 2'd0;
      ppi_reset   <= 1'b0;
      ppi_d_out   <= 8'h00;
      ppi_d_oe    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      init_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init_req) begin
            state     <= S_CHIPRST;
            cnt       <= RST_LD;
            ppi_reset <= 1'b1;
          end else if (bus.cmd_valid) begin
            state     <= S_SETUP;
            cnt       <= SETUP_LD;
            lat_write <= bus.cmd_write;
            ppi_cs_n  <= 1'b0;
            ppi_a     <= bus.cmd_addr;
            ppi_d_oe  <= bus.cmd_write;
            ppi_d_out <= bus.cmd_write ? bus.cmd_wdata : 8'h00;
          end
        end
        S_SETUP: begin
          if (cnt_done) begin
            state    <= S_STROBE;
            cnt      <= STROBE_LD;
            ppi_rd_n <= lat_write;
            ppi_wr_n <= !lat_write;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STROBE: begin
          if (cnt_done) begin
            state    <= S_HOLD;
            cnt      <= HOLD_LD;
            ppi_rd_n <= 1'b1;
            ppi_wr_n <= 1'b1;
            rdata_q  <= lat_write ? 8'h00 : ppi_d_in;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_done) begin
            state       <= S_RECOVER;
            cnt         <= REC_LD;
            ppi_cs_n    <= 1'b1;
            ppi_d_oe    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= lat_write;
            // Bit-set/reset words (bit 7 clear) do not change the port configuration.
            if (lat_write && ppi_a == ADDR_CTRL && ppi_d_out[MODE_SET])
              ctrl_shadow <= ppi_d_out;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RECOVER: begin
          if (cnt_done) state <= S_IDLE;
          else          cnt   <= cnt - 1'b1;
        end
        S_CHIPRST: begin
          if (cnt_done) begin
            state       <= S_IDLE;
            ppi_reset   <= 1'b0;
            init_done   <= 1'b1;
            ctrl_shadow <= CTRL_RESET_VAL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
